// File: rtl/event_debouncer.sv
// Event input conditioner: synchronizer, stability-counter debounce FSM and
// single-cycle pulse on the accepted edge selected by PULSE_ON_RISE.
module event_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter bit          PULSE_ON_RISE   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  input  logic clear,
  output logic level,
  output logic pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam bit                   ACCEPT_NOW = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic                   level_n, pulse_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], in_raw};
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    pulse_n = 1'b0;
    // clear wins over a same-edge acceptance, suppressing its pulse
    if (clear) begin
      state_n = STABLE_LO;
      cnt_n   = '0;
      level_n = 1'b0;
    end else begin
      case (state)
        STABLE_LO: if (s) begin
          if (ACCEPT_NOW) begin
            state_n = STABLE_HI;
            level_n = 1'b1;
            pulse_n = PULSE_ON_RISE;
            cnt_n   = '0;
          end else begin
            state_n = WAIT_HI;
            cnt_n   = CNT_WIDTH'(1);
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_n = STABLE_LO;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = STABLE_HI;
            level_n = 1'b1;
            pulse_n = PULSE_ON_RISE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_WIDTH'(1);
          end
        end
        STABLE_HI: if (!s) begin
          if (ACCEPT_NOW) begin
            state_n = STABLE_LO;
            level_n = 1'b0;
            pulse_n = ~PULSE_ON_RISE;
            cnt_n   = '0;
          end else begin
            state_n = WAIT_LO;
            cnt_n   = CNT_WIDTH'(1);
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_n = STABLE_HI;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = STABLE_LO;
            level_n = 1'b0;
            pulse_n = ~PULSE_ON_RISE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_event_debouncer.sv
// Bench for event_debouncer: default and alternate-parameter instances share
// stimulus and are compared each cycle against a run-length reference model.
module tb_event_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_raw = 1'b0;
  logic clear = 1'b0;
  logic level0, pulse0, busy0;
  logic level1, pulse1, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  event_debouncer u_dut (
    .clk(clk), .reset(reset), .in_raw(in_raw), .clear(clear),
    .level(level0), .pulse(pulse0), .busy(busy0)
  );

  event_debouncer #(
    .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(8), .PULSE_ON_RISE(1'b0)
  ) u_alt (
    .clk(clk), .reset(reset), .in_raw(in_raw), .clear(clear),
    .level(level1), .pulse(pulse1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Reference model: a change is accepted once the synchronized input has
  // disagreed with the debounced level for DEBOUNCE_CYCLES consecutive edges.
  int unsigned m_ss [2] = '{2, 3};
  int unsigned m_dc [2] = '{4, 1};
  bit          m_por[2] = '{1'b1, 1'b0};
  bit          m_level[2];
  bit          m_pulse[2];
  int unsigned m_run[2];
  bit          q0[$];
  bit          q1[$];

  int edge_no, np0, np1, fp0, fp1, fl0;
  bit prev_l0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_level[k] = 1'b0;
      m_pulse[k] = 1'b0;
      m_run[k]   = 0;
    end
    q0 = {};
    q1 = {};
    for (int unsigned i = 0; i < m_ss[0]; i++) q0.push_back(1'b0);
    for (int unsigned i = 0; i < m_ss[1]; i++) q1.push_back(1'b0);
  endtask

  task automatic model_edge(input int k, input bit s, input bit clr);
    m_pulse[k] = 1'b0;
    if (clr) begin
      m_level[k] = 1'b0;
      m_run[k]   = 0;
    end else if (s != m_level[k]) begin
      m_run[k]++;
      if (m_run[k] == m_dc[k]) begin
        m_level[k] = s;
        m_run[k]   = 0;
        m_pulse[k] = (s == m_por[k]);
      end
    end else begin
      m_run[k] = 0;
    end
  endtask

  task automatic check_all();
    check("level0", level0, m_level[0]);
    check("pulse0", pulse0, m_pulse[0]);
    check("busy0",  busy0,  m_run[0] != 0);
    check("level1", level1, m_level[1]);
    check("pulse1", pulse1, m_pulse[1]);
    check("busy1",  busy1,  m_run[1] != 0);
  endtask

  task automatic mark();
    edge_no = 0; np0 = 0; np1 = 0; fp0 = 0; fp1 = 0; fl0 = 0;
    prev_l0 = level0;
  endtask

  task automatic step();
    bit s;
    @(posedge clk);
    edge_no++;
    if (reset) begin
      s = q0.pop_front(); q0.push_back(in_raw); model_edge(0, s, clear);
      s = q1.pop_front(); q1.push_back(in_raw); model_edge(1, s, clear);
    end
    #1;
    check_all();
    if (pulse0) begin np0++; if (fp0 == 0) fp0 = edge_no; end
    if (pulse1) begin np1++; if (fp1 == 0) fp1 = edge_no; end
    if (level0 != prev_l0 && fl0 == 0) fl0 = edge_no;
    prev_l0 = level0;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int sinc;
    int run_left;

    // Reset held with in_raw high and clock running
    model_reset();
    #1;
    check_all();
    in_raw = 1'b1;
    repeat (5) step();
    check("rst_hold_lvl", level0, 0);
    check("rst_hold_busy", busy0, 0);
    in_raw = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (6) step();

    // Clean press and release
    mark();
    in_raw = 1'b1;
    repeat (12) step();
    check("press_lat", fp0, 6);
    check("press_np", np0, 1);
    check("press_lvl", level0, 1);
    check("alt_rise_np", np1, 0);
    sinc = np0;
    mark();
    in_raw = 1'b0;
    repeat (12) step();
    check("rel_lat", fl0, 6);
    check("rel_np", np0, 0);
    check("alt_fall_at", fp1, 4);
    check("sinc_cnt", sinc + np0, 1);

    // Bounce then steady high
    mark();
    for (int i = 0; i < 5; i++) begin
      in_raw = pat[i];
      step();
      if (i == 4) check("bounce_busy", busy0, 1);
    end
    in_raw = 1'b1;
    repeat (15) step();
    check("bounce_np", np0, 1);
    check("bounce_at", fp0, 11);
    in_raw = 1'b0;
    repeat (12) step();

    // Short glitch below the debounce threshold
    mark();
    in_raw = 1'b1;
    repeat (3) step();
    in_raw = 1'b0;
    repeat (10) step();
    check("glitch_np", np0, 0);
    check("glitch_lvl", level0, 0);
    check("glitch_busy", busy0, 0);

    // Clear on the accepting edge
    mark();
    in_raw = 1'b1;
    repeat (5) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_pulse", pulse0, 0);
    check("clr_lvl", level0, 0);
    repeat (10) step();
    in_raw = 1'b0;
    repeat (12) step();

    // Reset mid-qualification, release with input already high
    in_raw = 1'b1;
    repeat (3) step();
    check("wait_busy", busy0, 1);
    #2;
    assert_reset();
    check("rst_async_busy", busy0, 0);
    repeat (2) step();
    reset = 1'b1;
    mark();
    repeat (10) step();
    check("rst_rel_at", fp0, 6);
    check("rst_rel_np", np0, 1);

    // Randomized runs with occasional clear and reset
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        in_raw   = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      clear = ($urandom_range(0, 49) == 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 399) == 0) assert_reset();
      step();
    end
    clear = 1'b0;
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
